// File: rtl/intalu_issue_queue_pkg.sv
// Shared uop types for the integer ALU issue path: op encoding, operand value, tag and queue entry.
package Uop;

    localparam int UOP_TAG_W = 5;
    localparam int VAL_W     = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } intalu_op_t;

    typedef logic [VAL_W-1:0]     val_t;
    typedef logic [UOP_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic       valid;
        intalu_op_t op;
        logic       s1_rdy;
        val_t       s1_val;
        tag_t       s1_tag;
        logic       s2_rdy;
        val_t       s2_val;
        tag_t       s2_tag;
        tag_t       dst;
    } iq_entry_t;

    function automatic logic wake_hit(input logic wb_valid, input tag_t wb_tag, input tag_t tag);
        return wb_valid && (wb_tag == tag);
    endfunction

endpackage

// File: rtl/intalu_iq_select.sv
// Oldest-first priority encoder: returns the lowest set index of req and whether any bit is set.
module intalu_iq_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/intalu_issue_queue.sv
// Collapsing, age-ordered issue queue feeding the integer ALU; snoops the writeback bus for operands.
// Optional same-cycle dispatch-to-issue bypass is enabled by defining INTALU_IQ_BYPASS_EN.
module intalu_issue_queue
    import Uop::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = UOP_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  intalu_op_t                 disp_op,
    input  logic                       disp_s1_rdy,
    input  val_t                       disp_s1_val,
    input  logic [TAG_W-1:0]           disp_s1_tag,
    input  logic                       disp_s2_rdy,
    input  val_t                       disp_s2_val,
    input  logic [TAG_W-1:0]           disp_s2_tag,
    input  logic [TAG_W-1:0]           disp_dst,
    input  logic                       wb_valid,
    input  logic [TAG_W-1:0]           wb_tag,
    input  val_t                       wb_val,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output intalu_op_t                 iss_op,
    output val_t                       iss_s1,
    output val_t                       iss_s2,
    output logic [TAG_W-1:0]           iss_dst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    iq_entry_t        q   [DEPTH];
    iq_entry_t        q_n [DEPTH];
    iq_entry_t        disp_e;
    logic [CW-1:0]    count_n;
    logic [CW-1:0]    wr_slot;
    logic [DEPTH-1:0] rdy_vec;
    logic [IW-1:0]    sel_idx;
    logic             sel_any;
    logic             disp_acc;
    logic             disp_full_rdy;
    logic             byp;
    logic             stored_issue;
    logic             disp_write;
    tag_t             wtag;

    assign wtag = tag_t'(wb_tag);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = q[i].valid & q[i].s1_rdy & q[i].s2_rdy;
        end
    end

    intalu_iq_select #(.N(DEPTH), .IW(IW)) u_select (
        .req (rdy_vec),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Dispatched operands also catch a writeback landing in the same cycle
    always_comb begin
        disp_e.valid  = 1'b1;
        disp_e.op     = disp_op;
        disp_e.s1_rdy = disp_s1_rdy | wake_hit(wb_valid, wtag, tag_t'(disp_s1_tag));
        disp_e.s1_val = disp_s1_rdy ? disp_s1_val : wb_val;
        disp_e.s1_tag = tag_t'(disp_s1_tag);
        disp_e.s2_rdy = disp_s2_rdy | wake_hit(wb_valid, wtag, tag_t'(disp_s2_tag));
        disp_e.s2_val = disp_s2_rdy ? disp_s2_val : wb_val;
        disp_e.s2_tag = tag_t'(disp_s2_tag);
        disp_e.dst    = tag_t'(disp_dst);
    end

    assign disp_ready    = (count < CW'(DEPTH));
    assign disp_acc      = disp_valid & disp_ready & ~flush;
    assign disp_full_rdy = disp_e.s1_rdy & disp_e.s2_rdy;

`ifdef INTALU_IQ_BYPASS_EN
    assign byp = ~sel_any & disp_acc & disp_full_rdy;
`else
    assign byp = 1'b0;
`endif

    assign iss_valid    = (sel_any | byp) & ~flush;
    assign iss_op       = byp ? disp_e.op     : q[sel_idx].op;
    assign iss_s1       = byp ? disp_e.s1_val : q[sel_idx].s1_val;
    assign iss_s2       = byp ? disp_e.s2_val : q[sel_idx].s2_val;
    assign iss_dst      = TAG_W'(byp ? disp_e.dst : q[sel_idx].dst);

    assign stored_issue = sel_any & iss_ready & ~flush;
    assign disp_write   = disp_acc & ~(byp & iss_ready);
    assign wr_slot      = stored_issue ? count - CW'(1) : count;

    // Collapse above the issued slot, then wake, then drop the new uop into the tail
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_n[i] = q[i];
            if (stored_issue && (int'(sel_idx) <= i)) begin
                if (i < DEPTH - 1) q_n[i] = q[(i < DEPTH - 1) ? i + 1 : i];
                else               q_n[i].valid = 1'b0;
            end
            if (q_n[i].valid && !q_n[i].s1_rdy && wake_hit(wb_valid, wtag, q_n[i].s1_tag)) begin
                q_n[i].s1_rdy = 1'b1;
                q_n[i].s1_val = wb_val;
            end
            if (q_n[i].valid && !q_n[i].s2_rdy && wake_hit(wb_valid, wtag, q_n[i].s2_tag)) begin
                q_n[i].s2_rdy = 1'b1;
                q_n[i].s2_val = wb_val;
            end
            if (disp_write && (int'(wr_slot) == i)) q_n[i] = disp_e;
            if (flush) q_n[i].valid = 1'b0;
        end
        count_n = flush ? '0 : count + CW'(disp_write) - CW'(stored_issue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        end else begin
            count <= count_n;
            for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
        end
    end

endmodule
